// File: rtl/max7219_pkg.sv
// Shared definitions for the MAX7219 serial driver.
//   FRAME_W       : serial frame width (4 don't-care bits, 4 address bits, 8 data bits)
//   REG_*         : MAX7219 register addresses
//   max7219_st_e  : serial driver FSM state encoding
//   make_frame()  : packs address/data into a frame, MSB first on the wire
package max7219_pkg;

    localparam int FRAME_W = 16;

    localparam logic [3:0] REG_NOOP         = 4'h0;
    localparam logic [3:0] REG_DIGIT0       = 4'h1;
    localparam logic [3:0] REG_DIGIT1       = 4'h2;
    localparam logic [3:0] REG_DIGIT2       = 4'h3;
    localparam logic [3:0] REG_DIGIT3       = 4'h4;
    localparam logic [3:0] REG_DIGIT4       = 4'h5;
    localparam logic [3:0] REG_DIGIT5       = 4'h6;
    localparam logic [3:0] REG_DIGIT6       = 4'h7;
    localparam logic [3:0] REG_DIGIT7       = 4'h8;
    localparam logic [3:0] REG_DECODE_MODE  = 4'h9;
    localparam logic [3:0] REG_INTENSITY    = 4'hA;
    localparam logic [3:0] REG_SCAN_LIMIT   = 4'hB;
    localparam logic [3:0] REG_SHUTDOWN     = 4'hC;
    localparam logic [3:0] REG_DISPLAY_TEST = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SCLK_LO = 3'd1,
        ST_SCLK_HI = 3'd2,
        ST_LATCH   = 3'd3,
        ST_DONE    = 3'd4
    } max7219_st_e;

    function automatic logic [FRAME_W-1:0] make_frame(input logic [3:0] addr,
                                                      input logic [7:0] data);
        return {4'b0000, addr, data};
    endfunction

endpackage

// File: rtl/max7219_serial_driver.sv
// MAX7219 serial driver: turns one address/data write strobe into a 16-bit
// frame on the DIN/CLK/LOAD three-wire interface, with busy/ack handshake.
//
// Ports:
//   i_clk, i_reset      : clock, asynchronous active-high reset
//   i_stb               : write request (accepted only in IDLE)
//   i_addr, i_data      : register address / data, sampled at acceptance
//   o_busy, o_ack       : frame in progress / one-cycle completion pulse
//   i_serial_din        : daisy-chain return (not used)
//   o_serial_dout       : serial data to DIN
//   o_serial_load       : LOAD/CS, rising edge latches the frame
//   o_serial_clk        : serial clock to CLK
//
// FSM states:
//   state      | meaning
//   IDLE       | waiting for i_stb
//   SCLK_LO    | sclk low, current bit on dout
//   SCLK_HI    | sclk high, device samples dout
//   LATCH      | raise load to latch the frame
//   DONE       | ack pulse, release busy
module max7219_serial_driver
    import max7219_pkg::*;
#(
    parameter int SCLK_PHASE_CYCLES = 1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_stb,
    output logic       o_busy,
    output logic       o_ack,
    input  logic [3:0] i_addr,
    input  logic [7:0] i_data,
    input  logic       i_serial_din,
    output logic       o_serial_dout,
    output logic       o_serial_load,
    output logic       o_serial_clk
);

    localparam int PH_W = (SCLK_PHASE_CYCLES > 1) ? $clog2(SCLK_PHASE_CYCLES) : 1;
    localparam logic [PH_W-1:0] PH_RELOAD = PH_W'(SCLK_PHASE_CYCLES - 1);

    max7219_st_e        state_q, state_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic [3:0]         bit_q, bit_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic               busy_q, busy_d;
    logic               ack_q, ack_d;
    logic               sclk_q, sclk_d;
    logic               load_q, load_d;
    logic               dout_q, dout_d;
    logic               phase_done;
    logic [FRAME_W-1:0] frame_in;

    // Daisy-chain return is not needed for a single device.
    logic unused_din;
    assign unused_din = i_serial_din;

    assign frame_in   = make_frame(i_addr, i_data);
    assign phase_done = (phase_q == '0);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            phase_q <= '0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            sclk_q  <= 1'b0;
            load_q  <= 1'b1;
            dout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            phase_q <= phase_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            sclk_q  <= sclk_d;
            load_q  <= load_d;
            dout_q  <= dout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        phase_d = phase_q;
        busy_d  = busy_q;
        ack_d   = 1'b0;
        sclk_d  = sclk_q;
        load_d  = load_q;
        dout_d  = dout_q;

        unique case (state_q)
            ST_IDLE: begin
                if (i_stb) begin
                    shift_d = frame_in;
                    bit_d   = 4'd15;
                    phase_d = PH_RELOAD;
                    busy_d  = 1'b1;
                    load_d  = 1'b0;
                    dout_d  = frame_in[FRAME_W-1];
                    state_d = ST_SCLK_LO;
                end
            end

            ST_SCLK_LO: begin
                if (phase_done) begin
                    sclk_d  = 1'b1;
                    phase_d = PH_RELOAD;
                    state_d = ST_SCLK_HI;
                end else begin
                    phase_d = phase_q - PH_W'(1);
                end
            end

            ST_SCLK_HI: begin
                if (phase_done) begin
                    // dout only ever moves together with the sclk falling edge.
                    sclk_d  = 1'b0;
                    phase_d = PH_RELOAD;
                    if (bit_q != 4'd0) begin
                        bit_d   = bit_q - 4'd1;
                        shift_d = shift_q << 1;
                        dout_d  = shift_q[FRAME_W-2];
                        state_d = ST_SCLK_LO;
                    end else begin
                        state_d = ST_LATCH;
                    end
                end else begin
                    phase_d = phase_q - PH_W'(1);
                end
            end

            ST_LATCH: begin
                // ack is registered, so it is high exactly during DONE,
                // the last cycle that busy is high.
                sclk_d  = 1'b0;
                load_d  = 1'b1;
                ack_d   = 1'b1;
                state_d = ST_DONE;
            end

            ST_DONE: begin
                busy_d  = 1'b0;
                dout_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_busy        = busy_q;
    assign o_ack         = ack_q;
    assign o_serial_clk  = sclk_q;
    assign o_serial_load = load_q;
    assign o_serial_dout = dout_q;

endmodule

// File: tb/tb_max7219_serial_driver.sv
module tb_max7219_serial_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       stb = 1'b0;
    logic [3:0] addr = 4'h0;
    logic [7:0] data = 8'h00;
    logic       busy, ack, sdout, sload, sclk;

    max7219_serial_driver #(.SCLK_PHASE_CYCLES(1)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_stb        (stb),
        .o_busy       (busy),
        .o_ack        (ack),
        .i_addr       (addr),
        .i_data       (data),
        .i_serial_din (1'b0),
        .o_serial_dout(sdout),
        .o_serial_load(sload),
        .o_serial_clk (sclk)
    );

    always #5 clk = ~clk;

    // MAX7219 receiver model
    logic [15:0] rx_sr     = '0;
    logic [15:0] rx_frame  = '0;
    logic [7:0]  rx_reg [16];
    int          rises     = 0;
    int          bad_rises = 0;
    int          latches   = 0;
    int          acks      = 0;

    always @(posedge sclk) begin
        rx_sr <= {rx_sr[14:0], sdout};
        rises <= rises + 1;
        if (sload) bad_rises <= bad_rises + 1;
    end

    always @(posedge sload) begin
        rx_frame             <= rx_sr;
        rx_reg[rx_sr[11:8]]  <= rx_sr[7:0];
        latches              <= latches + 1;
    end

    always @(posedge clk) begin
        if (ack === 1'b1) acks <= acks + 1;
    end

    // Code B font (DP A B C D E F G, DP dropped) and its inverse
    function automatic logic [6:0] code_b(input logic [3:0] v);
        case (v)
            4'd0: return 7'h7E;  4'd1: return 7'h30;  4'd2: return 7'h6D;
            4'd3: return 7'h79;  4'd4: return 7'h33;  4'd5: return 7'h5B;
            4'd6: return 7'h5F;  4'd7: return 7'h70;  4'd8: return 7'h7F;
            4'd9: return 7'h7B;  default: return 7'h00;
        endcase
    endfunction

    function automatic logic [3:0] seg_to_bcd(input logic [6:0] s);
        case (s)
            7'h7E: return 4'd0;  7'h30: return 4'd1;  7'h6D: return 4'd2;
            7'h79: return 4'd3;  7'h33: return 4'd4;  7'h5B: return 4'd5;
            7'h5F: return 4'd6;  7'h70: return 4'd7;  7'h7F: return 4'd8;
            7'h7B: return 4'd9;  default: return 4'hF;
        endcase
    endfunction

    function automatic logic [3:0] digit_bcd(input int d);
        logic [7:0] dm, v;
        logic [6:0] seg;
        dm  = rx_reg[9];
        v   = rx_reg[d + 1];
        seg = dm[d] ? code_b(v[3:0]) : v[6:0];
        return seg_to_bcd(seg);
    endfunction

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    int busy_n, ack_n, rise_n, latch_n, bad_n;

    task automatic send(input logic [3:0] a, input logic [7:0] d, input bit glitch);
        int r0, l0, b0, a0, guard;
        @(posedge clk); #1;
        addr = a; data = d; stb = 1'b1;
        r0 = rises; l0 = latches; b0 = bad_rises; a0 = acks;
        @(posedge clk); #1;
        stb = 1'b0;
        busy_n = 0;
        guard  = 0;
        while (busy === 1'b1 && guard < 100) begin
            busy_n++;
            if (glitch && busy_n == 10) begin stb = 1'b1; addr = ~a; data = ~d; end
            if (glitch && busy_n == 12) begin stb = 1'b0; end
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 100) check("send_timeout", guard, 0);
        addr    = a;
        data    = d;
        ack_n   = acks - a0;
        rise_n  = rises - r0;
        latch_n = latches - l0;
        bad_n   = bad_rises - b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, busy,  0);
        check({tag, "_ack"},  ack,   0);
        check({tag, "_sclk"}, sclk,  0);
        check({tag, "_load"}, sload, 1);
        check({tag, "_dout"}, sdout, 0);
    endtask

    logic [3:0] cfg_a [3] = '{4'hA, 4'hB, 4'hC};
    logic [7:0] cfg_d [3] = '{8'h07, 8'h05, 8'h01};

    initial begin
        int r0, a0, l0, gap, guard;
        bit seen_busy;

        // reset
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("rst");
        r0 = rises;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_no_sclk", rises - r0, 0);
        check("rst_idle_busy", busy, 0);

        // single decode-mode write
        send(4'h9, 8'hFF, 1'b0);
        check("w1_frame", rx_frame, 16'h09FF);
        check("w1_rises", rise_n, 16);
        check("w1_busy_cycles", busy_n, 34);
        check("w1_acks", ack_n, 1);
        check("w1_latches", latch_n, 1);
        check("w1_rise_in_load", bad_n, 0);
        check_idle_outputs("w1_after");

        // configuration then digits 0..5
        for (int i = 0; i < 3; i++) begin
            send(cfg_a[i], cfg_d[i], 1'b0);
            check("cfg_lat", busy_n < 64, 1);
        end
        check("cfg_intensity", rx_reg[10], 8'h07);
        check("cfg_scan", rx_reg[11], 8'h05);
        check("cfg_shutdown", rx_reg[12], 8'h01);
        for (int i = 0; i < 6; i++) begin
            send(4'(i + 1), 8'(i), 1'b0);
            check("dig_lat", busy_n < 64, 1);
        end
        for (int i = 0; i < 6; i++) check("dig_bcd_a", digit_bcd(i), 32'(i));

        // rewrite digits 0..3 with 6..9
        for (int i = 0; i < 4; i++) begin
            send(4'(i + 1), 8'(i + 6), 1'b0);
            check("dig2_lat", busy_n < 64, 1);
        end
        for (int i = 0; i < 4; i++) check("dig_bcd_b", digit_bcd(i), 32'(i + 6));
        check("dig_bcd_keep4", digit_bcd(4), 4);
        check("dig_bcd_keep5", digit_bcd(5), 5);

        // display-test address and mid-frame strobe/input changes
        send(4'hF, 8'h01, 1'b0);
        check("dtest_frame", rx_frame, 16'h0F01);
        send(4'h2, 8'h03, 1'b1);
        check("glitch_frame", rx_frame, 16'h0203);
        check("glitch_acks", ack_n, 1);
        check("glitch_latches", latch_n, 1);
        check("glitch_busy", busy_n, 34);

        // strobe held across two frames
        @(posedge clk); #1;
        addr = 4'h7; data = 8'h12; stb = 1'b1;
        a0 = acks; l0 = latches; r0 = rises;
        gap = 0; seen_busy = 0; guard = 0;
        while (guard < 200) begin
            @(posedge clk); #1;
            guard++;
            if (acks - a0 >= 2) break;
            if (busy === 1'b1) seen_busy = 1;
            else if (seen_busy && (acks - a0) == 1) gap++;
        end
        stb = 1'b0;
        check("held_timeout", guard < 200, 1);
        check("held_acks", acks - a0, 2);
        check("held_latches", latches - l0, 2);
        check("held_rises", rises - r0, 32);
        check("held_gap", gap >= 1, 1);
        check("held_frame", rx_frame, 16'h0712);
        repeat (3) @(posedge clk); #1;
        check("held_no_third", busy, 0);

        // reset at bit 8
        @(posedge clk); #1;
        addr = 4'h3; data = 8'h44; stb = 1'b1;
        r0 = rises; a0 = acks;
        @(posedge clk); #1;
        stb = 1'b0;
        guard = 0;
        while (rises - r0 < 8 && guard < 60) begin
            @(posedge clk); #1;
            guard++;
        end
        check("mid_reach8", rises - r0, 8);
        #2 rst = 1'b1;
        #1;
        check_idle_outputs("mid_rst");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("mid_no_ack", acks - a0, 0);
        send(4'h4, 8'h08, 1'b0);
        check("post_frame", rx_frame, 16'h0408);
        check("post_rises", rise_n, 16);
        check("post_acks", ack_n, 1);
        check("post_busy", busy_n, 34);
        check("post_bcd", digit_bcd(3), 8);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/max7219_serial_driver.md
Name: max7219_serial_driver

Overview:
- Bus-to-serial bridge that converts one register-write strobe (4-bit address, 8-bit data) into a 16-bit MAX7219 frame.
- Drives the MAX7219 three-wire interface: DIN, CLK, LOAD/CS.
- Sits between the clock/display controller logic and the off-chip 7-segment driver; one frame per request, with a busy/ack handshake back to the requester.

Parameters:
- SCLK_PHASE_CYCLES, 1, i_clk cycles per serial-clock phase (low or high). Serial clock = i_clk / (2*SCLK_PHASE_CYCLES).

Ports:
- i_clk  input  1  system clock; all logic on rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_stb  input  1  write request strobe.
- o_busy  output  1  frame in progress; new requests ignored.
- o_ack  output  1  one-cycle pulse when the frame has been latched.
- i_addr  input  4  MAX7219 register address (frame D11..D8).
- i_data  input  8  register data (frame D7..D0).
- i_serial_din  input  1  daisy-chain return; unused, ignored.
- o_serial_dout  output  1  serial data to MAX7219 DIN.
- o_serial_load  output  1  LOAD/CS; rising edge latches the frame.
- o_serial_clk  output  1  serial clock to MAX7219 CLK.

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values:
  - o_busy=0, o_ack=0, o_serial_clk=0, o_serial_load=1, o_serial_dout=0.
  - FSM=IDLE; shift register and bit counter cleared.
- Frame: {4'b0000, i_addr, i_data}, 16 bits, shifted MSB first.
- Acceptance: in IDLE, i_stb=1 sampled at an edge accepts the request. On that edge:
  - latch the frame, set bit count=15, o_busy<=1, o_serial_load<=0, o_serial_dout<=frame[15].
- i_stb while o_busy=1 or outside IDLE is ignored.
- i_addr/i_data are sampled only at acceptance; later changes have no effect.
- States:
  - IDLE: wait for i_stb.
  - SCLK_LO: o_serial_clk=0, dout stable, for SCLK_PHASE_CYCLES cycles, then go to SCLK_HI.
  - SCLK_HI: o_serial_clk=1, dout unchanged, for SCLK_PHASE_CYCLES cycles.
    - If bits remain: drop sclk, present next bit, go to SCLK_LO.
    - Else: drop sclk, go to LATCH.
  - LATCH: o_serial_clk=0, o_serial_load<=1 (the rising edge latches the frame), go to DONE.
  - DONE: o_ack=1 for exactly one cycle, o_busy<=0, o_serial_dout<=0, return to IDLE.
- Data changes only while sclk is low. Each bit is held a full low+high period, so setup/hold around the sclk rising edge is one phase.
- Latency with default parameter:
  - o_busy high for 34 cycles (32 shift + LATCH + DONE).
  - o_ack asserts in the last busy cycle.
  - Next request may be accepted the cycle after o_busy falls.
- Exactly 16 rising sclk edges per frame; no sclk edges while load=1.
- Back-to-back: a strobe held continuously is re-accepted in IDLE after DONE. The requester deasserts i_stb once o_busy is seen high.
- Reset mid-frame:
  - Immediate return to the reset values above. The load rises, so the MAX7219 may latch a partial frame; this is acceptable.
  - No ack is generated.
- All-ones address (0xF, display-test) and all addresses 0x0–0xF are passed through unchanged; no decoding.

Decomposition:
- Shared package max7219_pkg:
  - FRAME_W=16.
  - Register address constants: NOOP=0x0, DIGIT0..DIGIT7=0x1..0x8, DECODE_MODE=0x9, INTENSITY=0xA, SCAN_LIMIT=0xB, SHUTDOWN=0xC, DISPLAY_TEST=0xF.
  - FSM state enum.
- Single module; no sub-module needed. The sclk phase counter is inline.
- Verification models live in the bench:
  - MAX7219 receiver model: shifts on sclk rise, commits on load rise, exposes digits 0–7.
  - 7-segment-to-BCD decoder.

Test Plan:
- Reset -> busy=0, ack=0, sclk=0, load=1, dout=0; no sclk edges during or after reset.
- Write addr=0x9, data=0xFF -> receiver captures 0x09FF; 16 sclk rises; busy high 34 cycles; ack one cycle; load rises once after the 16th bit.
- Config sequence (0xA=0x07, 0xB=0x05, 0xC=0x01), then addr 0x1..0x6 with data 0x00..0x05 -> decoded digits 0..5 read BCD 0..5. Rewrite addr 0x1..0x4 with 0x06..0x09 -> digits read 6..9. Each write completes in under 64 cycles.
- i_stb pulsed and i_addr/i_data changed mid-frame -> ignored; frame unchanged; exactly one ack.
- i_stb held high across two frames -> two consecutive frames, each with its own ack; at least one idle cycle between them.
- Reset asserted at bit 8 -> outputs return to reset values immediately, no ack; the next write completes correctly.
